// File: rtl/serial_input_receiver.sv
// LSB-first serial-to-parallel receiver with a valid/ready holding register and a sticky overrun flag.
// Optional even-parity bit after the data word when PARITY_CHECK_EN is defined.
module serial_input_receiver #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sin,
    input  logic                       sin_valid,
    input  logic                       start,
    output logic [WIDTH-1:0]           p_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
    output logic [WIDTH-1:0]           status,
    output logic                       overrun,
    input  logic                       ovr_clr,
    output logic                       parity_err
);

    localparam int BW = $clog2(WIDTH + 1);
`ifdef PARITY_CHECK_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [WIDTH-1:0]  shifted, data_word;
    logic [WIDTH-1:0]  p_out_q;
    logic              out_valid_q, overrun_q;
    logic              accept, done, load, par_calc;

    assign shifted = {sin, shift_q[WIDTH-1:1]};
    assign accept  = sin_valid && ((state_q == SHIFT) || start);

`ifdef PARITY_CHECK_EN
    // The trailing parity bit is consumed without disturbing the assembled data.
    assign data_word = shift_q;
    assign par_calc  = (^shift_q) ^ sin;
`else
    assign data_word = shifted;
    assign par_calc  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        done    = 1'b0;
        if (accept) begin
            if (start) begin
                // Fresh frame (or resync): discard any partial word.
                state_d = SHIFT;
                cnt_d   = BW'(1);
                shift_d = {sin, {(WIDTH-1){1'b0}}};
            end else if (cnt_q == BW'(FRAME - 1)) begin
                done    = 1'b1;
                state_d = IDLE;
                cnt_d   = '0;
                shift_d = data_word;
            end else begin
                cnt_d   = cnt_q + BW'(1);
                shift_d = shifted;
            end
        end
    end

    assign load = done && (!out_valid_q || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_out_q     <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (load) begin
                p_out_q     <= data_word;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (done && !load) begin
                overrun_q <= 1'b1;
            end else if (ovr_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

`ifdef PARITY_CHECK_EN
    logic par_err_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else if (load) begin
            par_err_q <= par_calc;
        end
    end
    assign parity_err = par_err_q;
`else
    logic unused_par;
    assign unused_par = par_calc;
    assign parity_err = 1'b0;
`endif

    assign p_out     = p_out_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q == SHIFT);
    assign bit_cnt   = cnt_q;
    assign status    = shift_q;

endmodule

// File: tb/tb_serial_input_receiver.sv
// Directed bench for serial_input_receiver (WIDTH=8); parity cases run when PARITY_CHECK_EN is defined.
module tb_serial_input_receiver;

    localparam int W = 8;
`ifdef PARITY_CHECK_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic         clk = 1'b0;
    logic         rst, sin, sin_valid, start, out_ready, ovr_clr;
    logic [W-1:0] p_out, status;
    logic         out_valid, busy, overrun, parity_err;
    logic [3:0]   bit_cnt;

    int total = 0;
    int bad   = 0;

    serial_input_receiver #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .start(start),
        .p_out(p_out), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .bit_cnt(bit_cnt), .status(status), .overrun(overrun), .ovr_clr(ovr_clr),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic st);
        @(negedge clk);
        sin_valid = v;
        sin       = s;
        start     = st;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic frame_bit(input logic [W-1:0] word, input logic par, input int i);
        logic [W-1:0] w;
        w = word;
        return (i < W) ? w[i] : par;
    endfunction

    // Drives frame bits lo..hi; the last one is left on the bus for the caller's next edge.
    task automatic send_range(input logic [W-1:0] word, input logic par, input int lo,
                              input int hi, input bit gap);
        for (int i = lo; i <= hi; i++) begin
            drive(1'b1, frame_bit(word, par, i), i == 0);
            if (gap && i != hi) begin
                drive(1'b0, 1'b0, 1'b0);
                check_eq("gap_bit_cnt", 32'(bit_cnt), 32'(i + 1));
                check_eq("gap_busy", 32'(busy), 32'd1);
            end
        end
    endtask

    task automatic send_word(input logic [W-1:0] word, input bit gap);
        send_range(word, ^word, 0, FRAME - 1, gap);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; start = 1'b0;
        out_ready = 1'b0; ovr_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_p_out", 32'(p_out), 32'h0);
        check_eq("rst_out_valid", 32'(out_valid), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_bit_cnt", 32'(bit_cnt), 32'h0);
        check_eq("rst_overrun", 32'(overrun), 32'h0);
        check_eq("rst_status", 32'(status), 32'h0);
        check_eq("rst_parity_err", 32'(parity_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Basic frame, consumer always ready.
        out_ready = 1'b1;
        send_word(8'hA5, 1'b0);
        check_eq("a5_pre_valid", 32'(out_valid), 32'h0);
        check_eq("a5_pre_cnt", 32'(bit_cnt), 32'(FRAME - 1));
        check_eq("a5_pre_busy", 32'(busy), 32'h1);
        settle();
        check_eq("a5_p_out", 32'(p_out), 32'hA5);
        check_eq("a5_valid", 32'(out_valid), 32'h1);
        check_eq("a5_busy", 32'(busy), 32'h0);
        check_eq("a5_cnt", 32'(bit_cnt), 32'h0);
        check_eq("a5_overrun", 32'(overrun), 32'h0);
        check_eq("a5_status", 32'(status), 32'hA5);
        check_eq("a5_parity_err", 32'(parity_err), 32'h0);
        drive(1'b0, 1'b0, 1'b0);
        settle();
        check_eq("a5_consumed", 32'(out_valid), 32'h0);
        check_eq("a5_kept", 32'(p_out), 32'hA5);

        // Gapped frame.
        send_word(8'h3C, 1'b1);
        settle();
        check_eq("3c_p_out", 32'(p_out), 32'h3C);
        check_eq("3c_valid", 32'(out_valid), 32'h1);
        drive(1'b0, 1'b0, 1'b0);
        settle();

        // Consumer stalled: second word dropped, overrun set then cleared.
        out_ready = 1'b0;
        send_word(8'h11, 1'b0);
        settle();
        check_eq("11_p_out", 32'(p_out), 32'h11);
        send_word(8'h22, 1'b0);
        settle();
        check_eq("22_drop_p_out", 32'(p_out), 32'h11);
        check_eq("22_overrun", 32'(overrun), 32'h1);
        check_eq("22_valid", 32'(out_valid), 32'h1);
        drive(1'b0, 1'b0, 1'b0);
        ovr_clr = 1'b1;
        settle();
        check_eq("ovr_clr", 32'(overrun), 32'h0);
        @(negedge clk);
        ovr_clr   = 1'b0;
        out_ready = 1'b1;
        settle();
        check_eq("stall_release", 32'(out_valid), 32'h0);
        check_eq("stall_kept", 32'(p_out), 32'h11);

        // Set beats clear on the same cycle.
        out_ready = 1'b0;
        send_word(8'h44, 1'b0);
        settle();
        send_range(8'h55, ^8'h55, 0, FRAME - 2, 1'b0);
        drive(1'b1, frame_bit(8'h55, ^8'h55, FRAME - 1), 1'b0);
        ovr_clr = 1'b1;
        settle();
        check_eq("set_wins", 32'(overrun), 32'h1);
        check_eq("set_wins_p_out", 32'(p_out), 32'h44);
        drive(1'b0, 1'b0, 1'b0);
        settle();
        check_eq("clr_after", 32'(overrun), 32'h0);
        ovr_clr = 1'b0;

        // Consume and refill on the same edge.
        send_range(8'h66, ^8'h66, 0, FRAME - 2, 1'b0);
        drive(1'b1, frame_bit(8'h66, ^8'h66, FRAME - 1), 1'b0);
        out_ready = 1'b1;
        settle();
        check_eq("refill_p_out", 32'(p_out), 32'h66);
        check_eq("refill_valid", 32'(out_valid), 32'h1);
        check_eq("refill_overrun", 32'(overrun), 32'h0);
        drive(1'b0, 1'b0, 1'b0);
        settle();
        check_eq("refill_consumed", 32'(out_valid), 32'h0);

        // Resync mid-frame, then a back-to-back frame.
        send_range(8'hFF, 1'b0, 0, 4, 1'b0);
        send_word(8'hF0, 1'b0);
        send_range(8'h96, ^8'h96, 0, 0, 1'b0);
        check_eq("resync_p_out", 32'(p_out), 32'hF0);
        check_eq("resync_overrun", 32'(overrun), 32'h0);
        check_eq("resync_idle", 32'(busy), 32'h0);
        send_range(8'h96, ^8'h96, 1, FRAME - 1, 1'b0);
        settle();
        check_eq("b2b_p_out", 32'(p_out), 32'h96);
        check_eq("b2b_valid", 32'(out_valid), 32'h1);

        // Unqualified bits in IDLE are ignored.
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        settle();
        check_eq("idle_ignore_busy", 32'(busy), 32'h0);
        check_eq("idle_ignore_cnt", 32'(bit_cnt), 32'h0);
        check_eq("idle_ignore_status", 32'(status), 32'h96);

        // Reset mid-frame.
        send_range(8'hFF, 1'b1, 0, 3, 1'b0);
        settle();
        check_eq("pre_rst_cnt", 32'(bit_cnt), 32'h4);
        drive(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        settle();
        check_eq("mid_rst_p_out", 32'(p_out), 32'h0);
        check_eq("mid_rst_status", 32'(status), 32'h0);
        check_eq("mid_rst_cnt", 32'(bit_cnt), 32'h0);
        check_eq("mid_rst_busy", 32'(busy), 32'h0);
        check_eq("mid_rst_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        send_word(8'h81, 1'b0);
        settle();
        check_eq("81_p_out", 32'(p_out), 32'h81);
        check_eq("81_status", 32'(status), 32'h81);

`ifdef PARITY_CHECK_EN
        drive(1'b0, 1'b0, 1'b0);
        send_range(8'h07, 1'b1, 0, FRAME - 1, 1'b0);
        settle();
        check_eq("par_ok_err", 32'(parity_err), 32'h0);
        check_eq("par_ok_p_out", 32'(p_out), 32'h07);
        drive(1'b0, 1'b0, 1'b0);
        send_range(8'h07, 1'b0, 0, FRAME - 1, 1'b0);
        settle();
        check_eq("par_bad_err", 32'(parity_err), 32'h1);
        check_eq("par_bad_p_out", 32'(p_out), 32'h07);
`else
        check_eq("par_tied", 32'(parity_err), 32'h0);
`endif

        drive(1'b0, 1'b0, 1'b0);
        settle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
